// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: freezes the pipeline around SRAM accesses and
// resolves hazard/branch priority. Optional perf counters under PIPE_PERF_CNT_EN.
module pipe_ctrl #(
   parameter int SRAM_WAIT = 4,
   parameter int PERF_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_req,
   input  logic              hazard,
   input  logic              branch_taken,
   output logic              freeze_if,
   output logic              flush_if,
   output logic              flush_id,
   output logic              freeze_all,
   output logic              mem_ready,
   output logic              pc_sel_branch
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [PERF_W-1:0] stall_cnt,
   output logic [PERF_W-1:0] flush_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, MEM_WAIT, MEM_DONE} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(SRAM_WAIT - 1);

   if (SRAM_WAIT < 1 || SRAM_WAIT > 15 || PERF_W < 1) begin : g_bad_param
      $error("pipe_ctrl: illegal parameter value");
   end

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       br_pend_q, br_pend_d;
   logic       br_eff;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         br_pend_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         br_pend_q <= br_pend_d;
      end
   end

   // cnt holds the MEM_WAIT cycles still to go, so the freeze (IDLE request cycle
   // plus MEM_WAIT cycles) lasts exactly SRAM_WAIT cycles.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (mem_req) begin
               if (SRAM_WAIT == 1) begin
                  state_d = MEM_DONE;
                  cnt_d   = 4'd0;
               end else begin
                  state_d = MEM_WAIT;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         MEM_WAIT: begin
            if (cnt_q <= 4'd1) begin
               state_d = MEM_DONE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         MEM_DONE: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   assign freeze_all = ((state_q == IDLE) && mem_req) || (state_q == MEM_WAIT);
   assign mem_ready  = (state_q == MEM_DONE);

   // A branch seen while frozen is remembered and taken on the first free cycle.
   assign br_eff        = rst && (branch_taken || br_pend_q) && !freeze_all;
   assign flush_if      = br_eff;
   assign pc_sel_branch = br_eff;
   assign flush_id      = br_eff || (rst && hazard && !freeze_all);
   assign freeze_if     = freeze_all || (!br_eff && hazard);
   assign br_pend_d     = br_eff ? 1'b0 : (br_pend_q || (branch_taken && freeze_all));

`ifdef PIPE_PERF_CNT_EN
   logic [PERF_W-1:0] stall_q, flush_q;

   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
      return (en && (v != '1)) ? v + 1'b1 : v;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         stall_q <= sat_inc(stall_q, freeze_all);
         flush_q <= sat_inc(flush_q, br_eff);
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`endif

endmodule
